// File: rtl/wb_irq_ctrl.sv
// wb_irq_ctrl - Wishbone-slave interrupt controller feeding the LM32 interrupt_n input.
//
// Raw active-high requests are synchronised, then either latched on a rising edge
// (edge mode) or tracked as a level (level mode). The pending vector is masked and
// presented to the CPU as a registered, active-low 32-bit vector.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   wb_adr_i  byte address, word offset taken from [4:2]
//   wb_dat_i  write data
//   wb_dat_o  read data, valid while wb_ack_o is high, zero otherwise
//   wb_stb_i  strobe
//   wb_cyc_i  cycle
//   wb_we_i   1 = write
//   wb_sel_i  byte-lane enables for writes
//   wb_ack_o  single-cycle acknowledge, never back-to-back
//   irq_i     raw requests, asynchronous to clk
//   intr_n    active-low requests to the CPU; bits >= NUM_IRQ held at 1
//
// Register map (word offset):
//   0 PEND (R, W1C)  1 MASK (RW)  2 MODE (RW, 1=edge)  3 RAW (RO)
//   4 ACTIVE (RO)    5 SWSET (W1S, edge bits only, reads 0)  6,7 reserved

module wb_irq_ctrl #(
  parameter int NUM_IRQ     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  input  logic               wb_stb_i,
  input  logic               wb_cyc_i,
  input  logic               wb_we_i,
  input  logic [3:0]         wb_sel_i,
  output logic               wb_ack_o,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [31:0]        intr_n
);

  localparam logic [2:0] OFF_PEND   = 3'd0;
  localparam logic [2:0] OFF_MASK   = 3'd1;
  localparam logic [2:0] OFF_MODE   = 3'd2;
  localparam logic [2:0] OFF_RAW    = 3'd3;
  localparam logic [2:0] OFF_ACTIVE = 3'd4;
  localparam logic [2:0] OFF_SWSET  = 3'd5;

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] irq_d_q;
  logic [NUM_IRQ-1:0] rise;

  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;
  logic [31:0]        intr_n_q, intr_n_d;

  logic               req;
  logic               wr;
  logic [2:0]         off;
  logic [31:0]        wmask32;
  logic [31:0]        wdat32;
  logic [NUM_IRQ-1:0] wmask;
  logic [NUM_IRQ-1:0] wdat;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] swset;
  logic [NUM_IRQ-1:0] to_edge;
  logic [NUM_IRQ-1:0] edge_pend;

  // Address bits outside the word offset and data/lane bits above NUM_IRQ are don't-care.
  logic unused_bits;
  assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], wdat32, wmask32};

  function automatic logic [31:0] zext(input logic [NUM_IRQ-1:0] v);
    logic [31:0] r;
    r = '0;
    r[NUM_IRQ-1:0] = v;
    return r;
  endfunction

  assign irq_s = sync_q[SYNC_STAGES-1];
  assign rise  = irq_s & ~irq_d_q;

  // A new access is accepted only while ack is low, which forces an idle clock between acks.
  assign req     = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr      = req & wb_we_i;
  assign off     = wb_adr_i[4:2];
  assign wmask32 = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wdat32  = wb_dat_i & wmask32;
  assign wmask   = wmask32[NUM_IRQ-1:0];
  assign wdat    = wdat32[NUM_IRQ-1:0];

  always_comb begin
    clr       = '0;
    swset     = '0;
    mask_d    = mask_q;
    mode_d    = mode_q;
    ack_d     = req;
    dat_d     = '0;
    intr_n_d  = '1;

    if (wr && off == OFF_PEND)  clr    = wdat;
    if (wr && off == OFF_SWSET) swset  = wdat;
    if (wr && off == OFF_MASK)  mask_d = (mask_q & ~wmask) | wdat;
    if (wr && off == OFF_MODE)  mode_d = (mode_q & ~wmask) | wdat;

    // Edge bits: clear first, then any set (hardware or software) wins.
    edge_pend = (pend_q & ~clr) | swset | rise;
    // Mode is applied as it stood before this clock, so a 1->0 write follows the level next clock.
    pend_d    = (mode_q & edge_pend) | (~mode_q & irq_s);
    // Level-to-edge switch discards the level-derived value, keeping only a fresh edge event.
    to_edge   = mode_d & ~mode_q;
    pend_d    = (pend_d & ~to_edge) | (to_edge & rise);

    if (req && !wb_we_i) begin
      unique case (off)
        OFF_PEND:   dat_d = zext(pend_q);
        OFF_MASK:   dat_d = zext(mask_q);
        OFF_MODE:   dat_d = zext(mode_q);
        OFF_RAW:    dat_d = zext(irq_s);
        OFF_ACTIVE: dat_d = zext(pend_q & mask_q);
        default:    dat_d = '0;
      endcase
    end

    intr_n_d[NUM_IRQ-1:0] = ~(pend_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      irq_d_q  <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      mode_q   <= '1;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      intr_n_q <= '1;
    end else begin
      sync_q[0] <= irq_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      irq_d_q  <= irq_s;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      intr_n_q <= intr_n_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign intr_n   = intr_n_q;

endmodule

// File: tb/tb_wb_irq_ctrl.sv
module tb_wb_irq_ctrl;
  localparam int N = 16;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  wb_adr_i;
  logic [31:0]  wb_dat_i;
  logic [31:0]  wb_dat_o;
  logic         wb_stb_i;
  logic         wb_cyc_i;
  logic         wb_we_i;
  logic [3:0]   wb_sel_i;
  logic         wb_ack_o;
  logic [N-1:0] irq_i;
  logic [31:0]  intr_n;

  int n_checks = 0;
  int n_fail   = 0;

  wb_irq_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o),
    .irq_i(irq_i), .intr_n(intr_n)
  );

  always #5 clk = ~clk;

  // Reference model: register state plus a history of sampled irq_i values.
  // hist[j] is irq_i as sampled j+1 edges ago (relative to the current edge).
  logic [N-1:0] m_pend, m_mask, m_mode;
  logic         m_ack;
  logic [31:0]  m_rdat;
  logic [31:0]  m_intr;
  logic [N-1:0] hist [0:S];

  always @(posedge clk) begin : model
    logic [N-1:0] s_old, d_old, np, wm, wd, rv, nmask, nmode;
    logic         req, rise;
    int           off;
    s_old = hist[S-1];
    d_old = hist[S];
    if (reset) begin
      m_pend <= '0; m_mask <= '0; m_mode <= '1;
      m_ack  <= 1'b0; m_rdat <= '0; m_intr <= '1;
      for (int j = 0; j <= S; j++) hist[j] <= '0;
    end else begin
      req = wb_stb_i && wb_cyc_i && !m_ack;
      off = int'(wb_adr_i[4:2]);
      for (int b = 0; b < N; b++) wm[b] = wb_sel_i[b/8];
      wd = wb_dat_i[N-1:0] & wm;
      case (off)
        0: rv = m_pend;
        1: rv = m_mask;
        2: rv = m_mode;
        3: rv = s_old;
        4: rv = m_pend & m_mask;
        default: rv = '0;
      endcase
      nmask = m_mask;
      nmode = m_mode;
      for (int b = 0; b < N; b++) begin
        if (req && wb_we_i && off == 1 && wm[b]) nmask[b] = wd[b];
        if (req && wb_we_i && off == 2 && wm[b]) nmode[b] = wd[b];
      end
      for (int i = 0; i < N; i++) begin
        rise = s_old[i] && !d_old[i];
        if (m_mode[i]) begin
          np[i] = m_pend[i];
          if (req && wb_we_i && off == 0 && wd[i]) np[i] = 1'b0;
          if (req && wb_we_i && off == 5 && wd[i]) np[i] = 1'b1;
          if (rise) np[i] = 1'b1;
        end else if (nmode[i]) begin
          np[i] = rise;
        end else begin
          np[i] = s_old[i];
        end
      end
      m_intr <= {{(32-N){1'b1}}, ~(m_pend & m_mask)};
      m_pend <= np;
      m_mask <= nmask;
      m_mode <= nmode;
      m_ack  <= req;
      m_rdat <= (req && !wb_we_i) ? {{(32-N){1'b0}}, rv} : 32'h0;
      hist[0] <= irq_i;
      for (int j = 1; j <= S; j++) hist[j] <= hist[j-1];
    end
  end

  // Bus access; called at a negedge, returns at the negedge following the ack edge.
  task automatic xfer(input logic we, input int off, input logic [31:0] d, input logic [3:0] sel,
                      output logic [31:0] rd, output logic ok);
    wb_adr_i = 32'(off) << 2;
    wb_dat_i = d;
    wb_we_i  = we;
    wb_sel_i = sel;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    ok = 1'b0;
    rd = '0;
    for (int n = 0; n < 4 && !ok; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (wb_ack_o) begin
        ok = 1'b1;
        rd = wb_dat_o;
      end
    end
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    logic        ok;
    logic [31:0] exp_v [0:7];
    exp_v[0] = 32'h0; exp_v[1] = 32'h0; exp_v[2] = 32'h0000FFFF; exp_v[3] = 32'h0;
    exp_v[4] = 32'h0; exp_v[5] = 32'h0; exp_v[6] = 32'h0;        exp_v[7] = 32'h0;
    n_checks++;
    if (intr_n !== 32'hFFFFFFFF || wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: intr_n=%h ack=%b dat=%h, required FFFFFFFF 0 0", intr_n, wb_ack_o, wb_dat_o);
    end
    for (int o = 0; o < 8; o++) begin
      xfer(1'b0, o, 32'h0, 4'hF, rd, ok);
      n_checks++;
      if (!ok || rd !== exp_v[o]) begin
        n_fail++;
        $display("FAIL reset_read off=%0d: got %h ack=%b, required %h", o, rd, ok, exp_v[o]);
      end
    end
  endtask

  task automatic test_edge_latency;
    logic [31:0] rd;
    logic        ok;
    int          low_at, highs;
    xfer(1'b1, 1, 32'h1, 4'hF, rd, ok);
    idle(2);
    irq_i[0] = 1'b1;
    low_at = -1;
    for (int n = 1; n <= 10 && low_at < 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) irq_i[0] = 1'b0;
      if (intr_n[0] === 1'b0) low_at = n;
    end
    n_checks++;
    if (low_at != S + 2) begin
      n_fail++;
      $display("FAIL edge_latency: intr_n[0] low after %0d edges, required %0d", low_at, S + 2);
    end
    highs = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (intr_n[0] !== 1'b0) highs++;
    end
    n_checks++;
    if (highs != 0) begin
      n_fail++;
      $display("FAIL edge_hold: intr_n[0] high on %0d cycles, required 0", highs);
    end
    xfer(1'b1, 0, 32'h1, 4'hF, rd, ok);
    n_checks++;
    if (intr_n[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL w1c_ack_edge: intr_n[0]=%b, required 0", intr_n[0]);
    end
    @(negedge clk);
    n_checks++;
    if (intr_n !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL w1c_release: intr_n=%h, required FFFFFFFF", intr_n);
    end
  endtask

  task automatic test_level;
    logic [31:0] rd;
    logic        ok;
    int          lows, high_at;
    xfer(1'b1, 2, 32'hFFFD, 4'hF, rd, ok);
    xfer(1'b1, 1, 32'h2, 4'hF, rd, ok);
    idle(2);
    irq_i[1] = 1'b1;
    lows = 0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (intr_n[1] === 1'b0) lows++;
    end
    n_checks++;
    if (lows != 5 - (S + 1)) begin
      n_fail++;
      $display("FAIL level_assert: intr_n[1] low on %0d of first 5 cycles, required %0d", lows, 5 - (S + 1));
    end
    xfer(1'b1, 0, 32'h2, 4'hF, rd, ok);
    xfer(1'b0, 0, 32'h0, 4'hF, rd, ok);
    n_checks++;
    if (rd !== 32'h2 || intr_n[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL level_w1c_ignored: PEND=%h intr_n[1]=%b, required 00000002 0", rd, intr_n[1]);
    end
    irq_i[1] = 1'b0;
    high_at = -1;
    for (int n = 1; n <= 10 && high_at < 0; n++) begin
      @(negedge clk);
      if (intr_n[1] === 1'b1) high_at = n;
    end
    n_checks++;
    if (high_at != S + 2) begin
      n_fail++;
      $display("FAIL level_release: intr_n[1] high after %0d edges, required %0d", high_at, S + 2);
    end
  endtask

  task automatic test_collision;
    logic [31:0] rd;
    logic        ok;
    xfer(1'b1, 0, 32'hFFFF, 4'hF, rd, ok);
    irq_i[3] = 1'b1;
    idle(S + 3);
    irq_i[3] = 1'b0;
    idle(S + 3);
    irq_i[3] = 1'b1;
    idle(S);
    xfer(1'b1, 0, 32'h8, 4'hF, rd, ok);
    irq_i[3] = 1'b0;
    xfer(1'b0, 0, 32'h0, 4'hF, rd, ok);
    n_checks++;
    if (rd[3] !== 1'b1 || rd !== m_rdat) begin
      n_fail++;
      $display("FAIL set_over_clear: PEND=%h, required bit3 set and %h", rd, m_rdat);
    end
  endtask

  task automatic test_masked;
    logic [31:0] rd;
    logic        ok;
    xfer(1'b1, 1, 32'h0, 4'hF, rd, ok);
    xfer(1'b1, 0, 32'hFFFF, 4'hF, rd, ok);
    xfer(1'b0, 0, 32'h0, 4'hF, rd, ok);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL w1c_clears: PEND=%h, required 00000000", rd);
    end
    irq_i[2] = 1'b1;
    @(negedge clk);
    irq_i[2] = 1'b0;
    idle(S + 3);
    n_checks++;
    if (intr_n !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL masked_intr: intr_n=%h, required FFFFFFFF", intr_n);
    end
    xfer(1'b0, 0, 32'h0, 4'hF, rd, ok);
    n_checks++;
    if (rd !== 32'h4) begin
      n_fail++;
      $display("FAIL masked_pend: PEND=%h, required 00000004", rd);
    end
    xfer(1'b1, 1, 32'h4, 4'hF, rd, ok);
    @(negedge clk);
    n_checks++;
    if (intr_n !== 32'hFFFFFFFB) begin
      n_fail++;
      $display("FAIL unmask: intr_n=%h, required FFFFFFFB", intr_n);
    end
  endtask

  task automatic test_swset_reset;
    logic [31:0] rd;
    logic        ok;
    xfer(1'b1, 2, 32'hFFFF, 4'hF, rd, ok);
    xfer(1'b1, 1, 32'hFFFF, 4'hF, rd, ok);
    xfer(1'b1, 0, 32'hFFFF, 4'hF, rd, ok);
    xfer(1'b1, 5, 32'h8001, 4'hF, rd, ok);
    @(negedge clk);
    n_checks++;
    if (intr_n !== 32'hFFFF7FFE) begin
      n_fail++;
      $display("FAIL swset_intr: intr_n=%h, required FFFF7FFE", intr_n);
    end
    xfer(1'b0, 5, 32'h0, 4'hF, rd, ok);
    n_checks++;
    if (rd !== 32'h0 || !ok) begin
      n_fail++;
      $display("FAIL swset_read: got %h ack=%b, required 00000000", rd, ok);
    end
    @(negedge clk);
    wb_adr_i = 32'h0; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_stb_i = 1'b1;  wb_cyc_i = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0 || intr_n !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL reset_mid_access: ack=%b dat=%h intr_n=%h, required 0 0 FFFFFFFF", wb_ack_o, wb_dat_o, intr_n);
    end
    reset = 1'b0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    @(negedge clk);
    xfer(1'b0, 0, 32'h0, 4'hF, rd, ok);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_pend: PEND=%h, required 00000000", rd);
    end
    xfer(1'b0, 1, 32'h0, 4'hF, rd, ok);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mask: MASK=%h, required 00000000", rd);
    end
    xfer(1'b0, 2, 32'h0, 4'hF, rd, ok);
    n_checks++;
    if (rd !== 32'h0000FFFF) begin
      n_fail++;
      $display("FAIL reset_mode: MODE=%h, required 0000FFFF", rd);
    end
  endtask

  task automatic test_random;
    logic [31:0] rd;
    logic        ok;
    logic        we;
    int          off;
    for (int t = 0; t < 300; t++) begin
      irq_i = irq_i ^ N'($urandom & $urandom & $urandom);
      we  = 1'($urandom_range(0, 1));
      off = $urandom_range(0, 7);
      xfer(we, off, $urandom, 4'($urandom_range(0, 15)), rd, ok);
      n_checks++;
      if (!ok || rd !== m_rdat) begin
        n_fail++;
        $display("FAIL rand_bus t=%0d off=%0d we=%b: got %h ack=%b, required %h", t, off, we, rd, ok, m_rdat);
      end
      for (int k = $urandom_range(0, 3); k >= 0; k--) begin
        n_checks++;
        if (intr_n !== m_intr) begin
          n_fail++;
          $display("FAIL rand_intr t=%0d: intr_n=%h, required %h", t, intr_n, m_intr);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    wb_we_i = 1'b0; wb_sel_i = 4'h0; irq_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset;
    test_edge_latency;
    test_level;
    test_collision;
    test_masked;
    test_swset_reset;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
